// File: rtl/frame_bank_sched_if.sv
// Bus bundle for the double-buffered frame store scheduler: SPI receive side,
// LCD read side, BRAM ports and status flags.
interface frame_bank_sched_if #(
    parameter int ADDR_WIDTH = 14
);
    // Receive path
    logic                  wr_start;
    logic                  wr_end;
    logic                  wr_valid;
    logic [7:0]            wr_data;

    // LCD side
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  frame_sync;
    logic                  err_clr;

    // BRAM ports
    logic                  mem_we;
    logic [ADDR_WIDTH:0]   mem_waddr;
    logic [7:0]            mem_wdata;
    logic [ADDR_WIDTH:0]   mem_raddr;

    // Status
    logic                  front_bank;
    logic                  frame_pending;
    logic                  rx_busy;
    logic                  err_overflow;
    logic                  err_short;
    logic [7:0]            frame_count;

    modport slave (
        input  wr_start, wr_end, wr_valid, wr_data, rd_addr, frame_sync, err_clr,
        output mem_we, mem_waddr, mem_wdata, mem_raddr,
        output front_bank, frame_pending, rx_busy, err_overflow, err_short, frame_count
    );

    modport master (
        output wr_start, wr_end, wr_valid, wr_data, rd_addr, frame_sync, err_clr,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr,
        input  front_bank, frame_pending, rx_busy, err_overflow, err_short, frame_count
    );
endinterface

// File: rtl/frame_bank_sched.sv
// Double-buffer scheduler: received frames land in the back bank and are swapped
// to the front only at an LCD frame boundary once a full frame has arrived.
module frame_bank_sched #(
    parameter int ADDR_WIDTH  = 14,
    parameter int FRAME_BYTES = 16384
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    frame_bank_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // The count must be able to hold FRAME_BYTES itself, hence one extra bit.
    localparam logic [ADDR_WIDTH:0] FRAME_CNT = (ADDR_WIDTH+1)'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] wcount_q, wcount_d;
    logic                front_q, front_d;
    logic                we_q, we_d;
    logic [ADDR_WIDTH:0] waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                ovf_q, ovf_d;
    logic                short_q, short_d;
    logic [7:0]          fcount_q, fcount_d;
    logic [ADDR_WIDTH:0] cnt_after;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            wcount_q <= '0;
            front_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
            short_q  <= 1'b0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            wcount_q <= wcount_d;
            front_q  <= front_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
            short_q  <= short_d;
            fcount_q <= fcount_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcount_d  = wcount_q;
        front_d   = front_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        fcount_d  = fcount_q;
        cnt_after = wcount_q;
        // Clear first so a set event later in this block overrides it.
        ovf_d     = ovf_q & ~bus.err_clr;
        short_d   = short_q & ~bus.err_clr;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr_start) begin
                    state_d  = ST_RECV;
                    wcount_d = '0;
                end
            end

            ST_RECV: begin
                if (bus.wr_valid) begin
                    if (wcount_q < FRAME_CNT) begin
                        we_d      = 1'b1;
                        waddr_d   = {~front_q, wcount_q[ADDR_WIDTH-1:0]};
                        wdata_d   = bus.wr_data;
                        cnt_after = wcount_q + CNT_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                wcount_d = cnt_after;

                if (bus.wr_start) begin
                    short_d  = 1'b1;
                    wcount_d = '0;
                end else if (bus.wr_end) begin
                    // Judged on the post-increment count so a final byte on the end cycle counts.
                    if (cnt_after == FRAME_CNT) begin
                        state_d = ST_PENDING;
                    end else begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_PENDING: begin
                if (bus.frame_sync) begin
                    front_d  = ~front_q;
                    fcount_d = fcount_q + 8'd1;
                    state_d  = ST_IDLE;
                end
                // A new frame start drops the pending one unless the swap lands first.
                if (bus.wr_start) begin
                    state_d  = ST_RECV;
                    wcount_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_we        = we_q;
    assign bus.mem_waddr     = waddr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_raddr     = {front_q, bus.rd_addr};
    assign bus.front_bank    = front_q;
    assign bus.frame_pending = (state_q == ST_PENDING);
    assign bus.rx_busy       = (state_q == ST_RECV);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_short     = short_q;
    assign bus.frame_count   = fcount_q;

endmodule

// File: doc/frame_bank_sched.md
Name: frame_bank_sched

Overview:
Double-buffer scheduler for the image frame store. The SPI receive path writes only into the back bank, and the LCD controller reads only from the front bank. Banks swap at the LCD frame boundary, and only after a complete frame has been received, so the display never tears or shows a partial image. The block sits between esp_interface/top-level receive logic and a 2-bank BSRAM image buffer. It also supplies frame status for the debug LEDs.

Parameters:
ADDR_WIDTH, 14, per-bank byte address width; physical BRAM address is ADDR_WIDTH+1 bits.
FRAME_BYTES, 16384, bytes per complete frame; must be >= 2 and <= 2**ADDR_WIDTH.

Ports:
sys_clk  in  1  system clock (27 MHz).
sys_rst  in  1  asynchronous reset, active-high.
wr_start  in  1  single-cycle pulse on CS falling edge; starts a frame.
wr_end  in  1  single-cycle pulse on CS rising edge; ends a frame.
wr_valid  in  1  received byte strobe, one cycle per byte.
wr_data  in  8  received byte.
rd_addr  in  ADDR_WIDTH  LCD logical read address.
frame_sync  in  1  single-cycle pulse at LCD vertical blanking start.
err_clr  in  1  clears the sticky error flags.
mem_we  out  1  BRAM write enable.
mem_waddr  out  ADDR_WIDTH+1  BRAM write address = {~front_bank, wcount}.
mem_wdata  out  8  BRAM write data.
mem_raddr  out  ADDR_WIDTH+1  BRAM read address = {front_bank, rd_addr}; combinational.
front_bank  out  1  bank currently displayed.
frame_pending  out  1  complete frame waiting in the back bank.
rx_busy  out  1  state == RECV.
err_overflow  out  1  sticky; a byte arrived after FRAME_BYTES.
err_short  out  1  sticky; a frame ended or restarted before FRAME_BYTES bytes.
frame_count  out  8  number of completed swaps, wraps at 255 -> 0.

Behaviour:
- Reset (async, sys_rst=1):
  - State is IDLE; wcount=0; front_bank=0.
  - All outputs are 0, except mem_raddr, which follows rd_addr.
- States: IDLE, RECV, PENDING. frame_pending = (state == PENDING).
- IDLE:
  - wr_start -> RECV, wcount=0.
  - wr_valid and wr_end are ignored; no write occurs.
- RECV:
  - wr_valid with wcount < FRAME_BYTES: the byte is written at {~front_bank, wcount}, then wcount increments.
  - wr_valid with wcount == FRAME_BYTES: no write; err_overflow=1.
  - wr_end: with wcount == FRAME_BYTES -> PENDING; otherwise err_short=1 -> IDLE.
  - wr_start: err_short=1, wcount=0, stay in RECV (restart).
  - Same-cycle wr_valid and wr_end: the byte is processed first; completion is judged on the incremented count.
- PENDING:
  - frame_sync: front_bank toggles, frame_count increments -> IDLE.
  - wr_start without frame_sync: the pending frame is discarded (no swap, no error) -> RECV, wcount=0.
  - Same-cycle frame_sync and wr_start: the swap happens, then RECV with wcount=0 targeting the new back bank (the old front).
- frame_sync in IDLE or RECV has no effect.
- Write port latency:
  - mem_we, mem_waddr and mem_wdata are registered, valid exactly 1 cycle after the accepted wr_valid.
  - mem_waddr uses the bank value sampled in the accept cycle.
- Error flags:
  - Sticky until err_clr=1.
  - A set event in the same cycle as err_clr wins (the flag is 1 next cycle).
- Bank invariant: a write never targets front_bank, including across the swap cycle.
- Reset mid-frame: state is lost and the pending frame is dropped; the display restarts from bank 0.

Test Plan:
All scenarios use FRAME_BYTES=16, ADDR_WIDTH=4.
- Nominal frame: wr_start, 16 wr_valid bytes 0x00..0x0F, wr_end -> writes at addresses 0x10..0x1F with matching data one cycle after each strobe; frame_pending=1. Then frame_sync -> front_bank=1, frame_count=1, mem_raddr={1,rd_addr}.
- Short frame: wr_start, 10 bytes, wr_end -> err_short=1; state IDLE; no swap on a following frame_sync (front_bank stays 0). err_clr -> err_short=0.
- Overflow: wr_start, 18 bytes, wr_end -> exactly 16 writes; err_overflow=1; frame_pending=1.
- Frame boundary race: while PENDING, assert frame_sync and wr_start in the same cycle -> front_bank=1, and the next write targets address 0x00 (bank 0).
- Stray bytes: wr_valid strobes while IDLE -> mem_we stays 0. Then wr_start, 16 bytes, wr_end -> 16 writes at addresses 0x10..0x1F, frame_pending=1 (the stray strobes had no effect).
- Mid-frame reset: assert sys_rst after 8 bytes -> outputs immediately 0 and front_bank=0. A subsequent full frame completes normally, with writes to bank 1.
